// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The FSM enum, frame geometry and checksum helper live here.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } loader_state_e;

    localparam int LOADER_CNT_BYTES  = 2;
    localparam int LOADER_WORD_BYTES = 4;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
// The loader is the slave; the stream source / memory side is the master.
interface imem_loader_if #(parameter int ADDR_W = 10);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output in_data, output in_valid, input in_ready,
                    input imem_we, input imem_addr, input imem_wdata);
    modport slave  (input in_data, input in_valid, output in_ready,
                    output imem_we, output imem_addr, output imem_wdata);
endinterface

// File: rtl/imem_loader_packer.sv
// Packs accepted bytes LSB-first into 32-bit words; flags the lane-3 byte.
// The assembled word is presented combinationally so the parent can register it.
module byte_word_packer
    import riscv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_LANE = 2'(LOADER_WORD_BYTES - 1);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] sr_q, sr_d;

    // Lane counter and shift register next-state
    always_comb begin
        lane_d     = lane_q;
        sr_d       = sr_q;
        word_valid = 1'b0;
        word       = {in_byte, sr_q[31:8]};
        if (clear) begin
            lane_d = 2'd0;
            sr_d   = 32'd0;
        end else if (accept) begin
            sr_d = word;
            if (lane_q == LAST_LANE) begin
                lane_d     = 2'd0;
                word_valid = 1'b1;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end else begin
            lane_d = lane_q;
        end
    end

    // Packer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= 2'd0;
            sr_q   <= 32'd0;
        end else begin
            lane_q <= lane_d;
            sr_q   <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: count, little-endian words, XOR checksum.
// Writes each word to imem and holds the CPU in reset until a good frame lands.
module imem_loader
    import riscv_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          reload,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_hold,
    output logic          done,
    output logic          err
);

    loader_state_e     state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       widx_q, widx_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              rdy_en_q;

    logic              accepting_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [15:0]       cnt_full_s;
    logic [31:0]       pk_word_s;
    logic              pk_valid_s;

    // rdy_en_q keeps in_ready low while rst is asserted, even though state is CNT_LO
    assign accepting_s = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                         (state_q == DATA)   || (state_q == CSUM);
    assign in_ready_s  = rdy_en_q && accepting_s && !reload;
    assign accept_s    = bus.in_valid && in_ready_s;
    assign cnt_full_s  = {bus.in_data, cnt_q[7:0]};

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (bus.in_data),
        .accept     (accept_s && (state_q == DATA)),
        .clear      (reload),
        .word       (pk_word_s),
        .word_valid (pk_valid_s)
    );

    // Frame FSM next-state and output register inputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        if (reload) begin
            state_d = CNT_LO;
            widx_d  = 16'd0;
            xor_d   = 8'd0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
        end else if (accept_s) begin
            case (state_q)
                CNT_LO: begin
                    cnt_d   = {8'd0, bus.in_data};
                    xor_d   = csum_next(xor_q, bus.in_data);
                    state_d = CNT_HI;
                end
                CNT_HI: begin
                    cnt_d = cnt_full_s;
                    xor_d = csum_next(xor_q, bus.in_data);
                    if (cnt_full_s > 16'(DEPTH)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end else if (cnt_full_s == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    xor_d = csum_next(xor_q, bus.in_data);
                    if (pk_valid_s) begin
                        we_d    = 1'b1;
                        addr_d  = widx_q[ADDR_W-1:0];
                        wdata_d = pk_word_s;
                        widx_d  = widx_q + 16'd1;
                        if ((widx_q + 16'd1) == cnt_q) begin
                            state_d = CSUM;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
                CSUM: begin
                    if (bus.in_data == xor_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CNT_LO;
            cnt_q    <= 16'd0;
            widx_q   <= 16'd0;
            xor_q    <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            xor_q    <= xor_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst_hold   = hold_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: valid, bad-checksum, oversize and empty frames,
// backpressure gaps, mid-frame reset and reload, with hand-computed expectations.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst;
    logic reload;
    logic cpu_rst_hold;
    logic done;
    logic err;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];

    imem_loader_if #(.ADDR_W(10)) bus();

    imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .reload       (reload),
        .bus          (bus),
        .cpu_rst_hold (cpu_rst_hold),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen on the imem port
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            tick(1);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: observed in_ready=0 expected 1");
            bus.in_valid = 1'b0;
        end else begin
            tick(1);
        end
    endtask

    task automatic send_frame(input byte_q_t fr, input int gap);
        foreach (fr[i]) begin
            send(fr[i]);
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                tick(gap);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_a0"}, 32'(wa_q[0]), 32'd0);
            check({tag, "_d0"}, wd_q[0], 32'h00A00093);
            check({tag, "_a1"}, 32'(wa_q[1]), 32'd1);
            check({tag, "_d1"}, wd_q[1], 32'h01400113);
        end
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick(1);
        check("reload_forces_ready_low", 32'(bus.in_ready), 32'd0);
        reload = 1'b0;
        #1;
        check("reload_ready", 32'(bus.in_ready), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_err", 32'(err), 32'd0);
        check("reload_hold", 32'(cpu_rst_hold), 32'd1);
    endtask

    byte_q_t good_fr;
    byte_q_t bad_fr;
    byte_q_t fr;

    initial begin
        good_fr = '{8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h40, 8'h01, 8'h62};
        bad_fr  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h40, 8'h01, 8'h63};
        rst          = 1'b0;
        reload       = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        tick(2);

        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_rst_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("ready_before_edge", 32'(bus.in_ready), 32'd0);
        tick(1);
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Valid load, no bubbles
        fr = good_fr[0:9];
        send_frame(fr, 0);
        check("valid_hold_pre_csum", 32'(cpu_rst_hold), 32'd1);
        send(8'h62);
        bus.in_valid = 1'b0;
        check("valid_done", 32'(done), 32'd1);
        check("valid_hold", 32'(cpu_rst_hold), 32'd0);
        check("valid_err", 32'(err), 32'd0);
        check("valid_ready_low", 32'(bus.in_ready), 32'd0);
        tick(2);
        check_two_writes("valid");

        // Reload from DONE, then bad checksum
        do_reload();
        send_frame(bad_fr, 0);
        check("badcs_err", 32'(err), 32'd1);
        check("badcs_done", 32'(done), 32'd0);
        check("badcs_hold", 32'(cpu_rst_hold), 32'd1);
        check("badcs_ready", 32'(bus.in_ready), 32'd0);
        tick(2);
        check_two_writes("badcs");

        // Word count 1025 exceeds DEPTH
        do_reload();
        send(8'h01);
        send(8'h04);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_ready", 32'(bus.in_ready), 32'd0);
        check("ovf_hold", 32'(cpu_rst_hold), 32'd1);
        bus.in_data = 8'h55;
        tick(3);
        check("ovf_still_blocked", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        check("ovf_nwr", 32'(wa_q.size()), 32'd0);
        wa_q.delete();
        wd_q.delete();

        // Empty frame
        do_reload();
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_hold", 32'(cpu_rst_hold), 32'd0);
        tick(2);
        check("empty_nwr", 32'(wa_q.size()), 32'd0);

        // Backpressure gaps of 3 idle cycles between bytes
        do_reload();
        fr = good_fr[0:9];
        send_frame(fr, 3);
        check("gap_hold_pre_csum", 32'(cpu_rst_hold), 32'd1);
        fr = '{8'h62};
        send_frame(fr, 3);
        check("gap_done", 32'(done), 32'd1);
        check("gap_hold", 32'(cpu_rst_hold), 32'd0);
        check_two_writes("gap");

        // Reset after two data bytes, then a fresh one-word frame
        do_reload();
        fr = '{8'h02, 8'h00, 8'h93, 8'h00};
        send_frame(fr, 0);
        rst = 1'b0;
        #1;
        check("midrst_hold", 32'(cpu_rst_hold), 32'd1);
        check("midrst_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_we", 32'(bus.imem_we), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(1);
        fr = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_frame(fr, 0);
        check("midrst_done", 32'(done), 32'd1);
        check("midrst_err", 32'(err), 32'd0);
        tick(2);
        check("midrst_nwr", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            check("midrst_a0", 32'(wa_q[0]), 32'd0);
            check("midrst_d0", wd_q[0], 32'h44332211);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory of `riscv_processor` from a byte stream, replacing backdoor testbench writes with a synthesizable path. It accepts a framed byte stream over a valid/ready handshake, packs little-endian 32-bit words, and issues one write per word on the imem write port. It holds the CPU in reset until a complete frame with a valid checksum has been loaded.

## Interface
Parameters:
- `ADDR_W`, default 10: imem word-address width.
- `DEPTH`, default 1024: imem words. A word count greater than DEPTH is a frame error.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, asynchronous and active-low.
- `in_data` in 8: stream byte.
- `in_valid` in 1: byte valid.
- `in_ready` out 1: loader can accept. A byte transfers when `in_valid && in_ready` at a rising edge.
- `reload` in 1: single-cycle pulse that restarts frame reception.
- `imem_we` out 1: one-cycle write strobe.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: word to write.
- `cpu_rst_hold` out 1: active-high reset request to the CPU.
- `done` out 1: frame loaded and checksum matched.
- `err` out 1: frame rejected.

## Operation
Frame format:
- Bytes 0–1: 16-bit word count N, LSB first.
- Next 4·N bytes: words, each LSB first.
- Final byte: checksum, equal to the XOR of every preceding frame byte, count bytes included.

States:
- CNT_LO: capture the count LSB. Go to CNT_HI.
- CNT_HI: capture the count MSB.
  - N > DEPTH: go to ERR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: byte lane counter 0..3 packs into a 32-bit shift register. On lane 3, issue the write, increment the word index, and clear the lane counter. After the Nth word, go to CSUM.
- CSUM: compare the received byte with the running XOR. Match goes to DONE; mismatch goes to ERR.
- DONE: `in_ready`=0, `done`=1, `cpu_rst_hold`=0.
- ERR: `in_ready`=0, `err`=1, `cpu_rst_hold`=1.

Handshake and reload:
- `in_ready` = 1 in CNT_LO, CNT_HI, DATA and CSUM, and forced to 0 in any cycle where `reload`=1.
- `reload` in any state returns to CNT_LO and clears the lane counter, word index, XOR accumulator, `done` and `err`. It also sets `cpu_rst_hold`=1.
- Bytes with `in_valid`=1 while `in_ready`=0 are not consumed. The source holds them.

Reset values (asynchronous, `rst`=0):
- `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
- `cpu_rst_hold`=1, `done`=0, `err`=0, `in_ready`=0.
- State is CNT_LO.
- `in_ready` rises in the first cycle after `rst` deasserts.

Reset mid-frame discards the partial word. Words already written are not erased.

## Timing
- `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- The address equals the word index, starting at 0.
- `done`/`err` and the `cpu_rst_hold` transition become visible the cycle after the checksum byte is accepted.
  - For the N > DEPTH case, they become visible the cycle after the count MSB is accepted.
- Throughput is one byte per cycle with no bubbles. Gaps in `in_valid` stall without state change.
- If the final data write strobe and the acceptance of the checksum byte fall in the same cycle, both complete.
- The running XOR updates on every accepted byte except the checksum byte.

## Structure
- `riscv_loader_pkg` holds:
  - the state enum (CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR);
  - the constants `LOADER_CNT_BYTES`=2 and `LOADER_WORD_BYTES`=4.
- One sub-module, `byte_word_packer`: lane counter plus 32-bit shift register. Its ports are:
  - inputs: byte, accept, clear;
  - outputs: word, word_valid.
- The top level holds the FSM, the word index, the XOR accumulator and the output registers.
- Integration: the `cpu_rst_hold` OR the board reset drives `riscv_processor.rst`.

## Test plan
- **Valid load.** Stream 02 00 93 00 A0 00 13 01 40 01 62 → two writes: addr 0 = 0x00A00093, addr 1 = 0x01400113. Then `done`=1 and `cpu_rst_hold`=0.
- **Bad checksum.** Same frame with checksum 0x63 → both writes occur, then `err`=1, `cpu_rst_hold` stays 1 and `in_ready`=0.
- **Count over DEPTH.** Count bytes 01 04 (1025) → `err`=1 in the cycle after the 2nd byte, no `imem_we`, and later bytes are not accepted.
- **Empty frame.** Stream 00 00 00 → `done`=1 with no writes.
- **Backpressure gaps.** Valid-load stream with `in_valid` dropped for 3 cycles between every byte → identical writes and values.
- **Reset and reload.**
  - Assert `rst` after 2 data bytes, then send a fresh frame → writes start at addr 0 with the correct data.
  - Pulse `reload` from DONE and resend → `cpu_rst_hold`=1 until the new `done`.
